// File: rtl/load_store_unit.sv
// Memory-access stage between execute and a word-addressed data memory.
// Handles byte/half/word loads (sign/zero-extended) and stores; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  store_done,
    output logic                  misalign_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // WR serves both plain word stores and the write half of a read-modify-write;
    // the lane merge below replaces every lane for a word store.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] LOAD   = 2'b01;
    localparam logic [1:0] RMW_RD = 2'b10;
    localparam logic [1:0] WR     = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [1:0]  state_reg, state_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic        write_reg;
    logic [31:0] merge_reg;
    logic [31:0] load_data_reg;
    logic        load_valid_reg;
    logic        misalign_reg;

    logic        accept;
    logic        illegal;
    logic [1:0]  offset;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    assign req_ready = (state_reg == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign illegal   = (req_size == 2'b11) ||
                       ((req_size == SIZE_HALF) && req_addr[0]) ||
                       ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign offset    = addr_reg[1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && !illegal) begin
                    if (!req_write)
                        state_next = LOAD;
                    else if (req_size == SIZE_WORD)
                        state_next = WR;
                    else
                        state_next = RMW_RD;
                end
            end
            LOAD:    state_next = IDLE;
            RMW_RD:  state_next = WR;
            WR:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Store lane enables and store data replicated into every candidate lane.
    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = wdata_reg;
        case (size_reg)
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << offset;
                wdata_rep = {4{wdata_reg[7:0]}};
            end
            SIZE_HALF: begin
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_reg[15:0]}};
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_wdata[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8]
                                                      : merge_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (offset)
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            2'd3:    lane_byte = mem_rdata[31:24];
            default: lane_byte = mem_rdata[7:0];
        endcase
        lane_half = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_reg)
            SIZE_BYTE: load_ext = {{24{signed_reg & lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_ext = {{16{signed_reg & lane_half[15]}}, lane_half};
            default:   load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            size_reg       <= '0;
            signed_reg     <= 1'b0;
            write_reg      <= 1'b0;
            merge_reg      <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            load_valid_reg <= (state_reg == LOAD);
            misalign_reg   <= accept && illegal;
            if (accept) begin
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
                size_reg   <= req_size;
                signed_reg <= req_signed;
                write_reg  <= req_write;
            end
            if (state_reg == LOAD)
                load_data_reg <= load_ext;
            if (state_reg == RMW_RD)
                merge_reg <= mem_rdata;
        end
    end

    // Memory strobes are gated by reset so an interrupted RMW never writes.
    assign mem_read     = !reset && ((state_reg == LOAD) || (state_reg == RMW_RD));
    assign mem_write    = !reset && (state_reg == WR) && write_reg;
    assign store_done   = mem_write;
    assign mem_addr     = {addr_reg[31:2], 2'b00};
    assign load_data    = load_data_reg;
    assign load_valid   = load_valid_reg;
    assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        store_done;
    logic        misalign_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int wr_cnt = 0, rd_cnt = 0, sd_cnt = 0, ovl_cnt = 0;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .load_data(load_data), .load_valid(load_valid),
        .store_done(store_done), .misalign_err(misalign_err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (store_done) sd_cnt <= sd_cnt + 1;
        if (mem_read && mem_write) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = data;
        #1 check("ready_before_issue", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, sz, sg, addr, 32'h0);
        check({tag, "_mem_read"}, {31'b0, mem_read}, 32'd1);
        check({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        check({tag, "_load_valid"}, {31'b0, load_valid}, 32'd1);
        check({tag, "_load_data"}, load_data, exp);
        $display("load  %s addr=%h size=%0d signed=%0d data=%h", tag, addr, sz, sg, load_data);
    endtask

    task automatic do_store(input string tag, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] expw);
        issue(1'b1, sz, 1'b0, addr, data);
        if (sz != 2'b10) begin
            check({tag, "_rmw_read"}, {31'b0, mem_read}, 32'd1);
            check({tag, "_rmw_nowrite"}, {31'b0, mem_write}, 32'd0);
            @(negedge clk);
        end
        check({tag, "_mem_write"}, {31'b0, mem_write}, 32'd1);
        check({tag, "_store_done"}, {31'b0, store_done}, 32'd1);
        check({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_mem_wdata"}, mem_wdata, expw);
        @(negedge clk);
        check({tag, "_mem_word"}, mem[addr[7:2]], expw);
        $display("store %s addr=%h size=%0d data=%h word=%h", tag, addr, sz, data, mem[addr[7:2]]);
    endtask

    initial begin
        int sd0, rd0, wr0;
        int acc_cyc [3];
        int nq;
        logic acc;
        logic [31:0] lv_data [$];

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        @(negedge clk); @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_load_valid", {31'b0, load_valid}, 32'd0);
        check("rst_load_data", load_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: word store then word load
        do_store("sw10", 2'b10, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lw10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

        // 2: byte store as read-modify-write
        do_store("sw20", 2'b10, 32'h20, 32'h11223344, 32'h11223344);
        sd0 = sd_cnt;
        do_store("sb22", 2'b00, 32'h22, 32'h000000AA, 32'h11AA3344);
        check("sb22_done_once", sd_cnt - sd0, 32'd1);

        // 3: extension cases
        do_store("sw30", 2'b10, 32'h30, 32'h8000F0FF, 32'h8000F0FF);
        do_load("lb30", 2'b00, 1'b1, 32'h30, 32'hFFFFFFFF);
        do_load("lbu31", 2'b00, 1'b0, 32'h31, 32'h000000F0);
        do_load("lh32", 2'b01, 1'b1, 32'h32, 32'hFFFF8000);
        do_load("lhu32", 2'b01, 1'b0, 32'h32, 32'h00008000);
        do_load("lbu33", 2'b00, 1'b0, 32'h33, 32'h00000080);
        do_store("sh30", 2'b01, 32'h32, 32'h0000CAFE, 32'hCAFEF0FF);

        // 4: misaligned and illegal requests
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1'b0, 2'b01, 1'b1, 32'h41, 32'h0);
        check("lh41_err", {31'b0, misalign_err}, 32'd1);
        check("lh41_ready", {31'b0, req_ready}, 32'd1);
        issue(1'b1, 2'b10, 1'b0, 32'h42, 32'h12345678);
        check("sw42_err", {31'b0, misalign_err}, 32'd1);
        issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        check("sz11_err", {31'b0, misalign_err}, 32'd1);
        @(negedge clk);
        check("err_pulse_end", {31'b0, misalign_err}, 32'd0);
        check("err_no_read", rd_cnt - rd0, 32'd0);
        check("err_no_write", wr_cnt - wr0, 32'd0);
        $display("misaligned requests done, ready=%0d", req_ready);

        // 5: reset during RMW_RD
        do_store("sw50", 2'b10, 32'h50, 32'h12345678, 32'h12345678);
        wr0 = wr_cnt;
        issue(1'b1, 2'b01, 1'b0, 32'h50, 32'h0000BEEF);
        reset = 1'b1;
        #1;
        check("rst_rmw_no_read", {31'b0, mem_read}, 32'd0);
        check("rst_rmw_no_write", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);
        check("post_rst_load_data", load_data, 32'h0);
        @(negedge clk);
        check("post_rst_no_write", wr_cnt - wr0, 32'd0);
        check("post_rst_mem", mem[5'h14], 32'h12345678);
        $display("reset mid-RMW done, mem[0x50]=%h", mem[5'h14]);

        // 6: back-to-back with req_valid held high
        nq = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (load_valid) lv_data.push_back(load_data);
            req_valid = (nq < 3);
            case (nq)
                0: begin req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h0; end
                1: begin req_write = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h55; end
                2: begin req_write = 1'b0; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h0; end
                default: ;
            endcase
            #1 acc = req_valid && req_ready;
            @(posedge clk);
            if (acc) begin acc_cyc[nq] = cyc; nq++; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_count", nq, 32'd3);
        check("b2b_acc0", acc_cyc[0], 32'd0);
        check("b2b_acc1", acc_cyc[1], 32'd2);
        check("b2b_acc2", acc_cyc[2], 32'd5);
        check("b2b_loads", lv_data.size(), 32'd2);
        if (lv_data.size() == 2) begin
            check("b2b_lw0", lv_data[0], 32'hDEADBEEF);
            check("b2b_lw1", lv_data[1], 32'h11AA3355);
        end
        $display("back-to-back accepted at %0d %0d %0d", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        check("no_read_write_overlap", ovl_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
